// File: rtl/bus_demux4_32_pkg.sv
// soc_bus_pkg: shared state encoding, slave indices and defaults for the SoC request router
package soc_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [1:0] SLV_RAM = 2'd0;
  localparam logic [1:0] SLV_ROM = 2'd1;
  localparam logic [1:0] SLV_GPIO = 2'd2;
  localparam logic [1:0] SLV_TMR = 2'd3;
  localparam int DEF_TIMEOUT = 15;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage

// File: rtl/bus_demux4_32_if.sv
// bus_demux4_32_if: master-side request bus plus the four slave ports of the router
interface bus_demux4_32_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        m_err;
  logic        m_busy;
  logic [3:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata0;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;
  logic [31:0] s_rdata3;
  logic [3:0]  s_ack;
  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata0, s_rdata1, s_rdata2, s_rdata3, s_ack,
    output m_rdata, m_ack, m_err, m_busy, s_req, s_we, s_addr, s_wdata
  );
  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata0, s_rdata1, s_rdata2, s_rdata3, s_ack,
    input  m_rdata, m_ack, m_err, m_busy, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/bus_demux4_32_rdata_sel4.sv
// rdata_sel4: 4:1 32-bit combinational read-data selector keyed by slave index
module rdata_sel4
  import soc_bus_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [31:0] i_d3,
  output logic [31:0] o_d
);
  always_comb o_d = i_sel == SLV_RAM  ? i_d0 :
                    i_sel == SLV_ROM  ? i_d1 :
                    i_sel == SLV_GPIO ? i_d2 :
                    i_sel == SLV_TMR  ? i_d3 : '0;
endmodule

// File: rtl/bus_demux4_32.sv
// bus_demux4_32: routes one registered master request to one of four slaves by addr[31:30],
// returns the slave's read data on ack, or ERR_DATA with an error pulse after TIMEOUT idle cycles
module bus_demux4_32
  import soc_bus_pkg::*;
#(
  parameter int          TIMEOUT  = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input logic clk,
  input logic rst_n,
  bus_demux4_32_if.slave bus
);
  state_t      r_state, w_state_nx;
  logic [1:0]  r_sel, w_sel_nx;
  logic        r_we, w_we_nx;
  logic [29:0] r_addr, w_addr_nx;
  logic [31:0] r_wdata, w_wdata_nx;
  logic [31:0] r_rdata, w_rdata_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic [3:0]  r_sreq, w_sreq_nx;
  logic        r_ack, w_ack_nx;
  logic        r_err, w_err_nx;
  logic        r_busy, w_busy_nx;
  logic [31:0] w_sel_rdata;
  logic        w_hit;
  logic        w_expired;
  rdata_sel4 u_rdata_sel4 (
    .i_sel(r_sel),
    .i_d0 (bus.s_rdata0),
    .i_d1 (bus.s_rdata1),
    .i_d2 (bus.s_rdata2),
    .i_d3 (bus.s_rdata3),
    .o_d  (w_sel_rdata)
  );
  assign w_hit     = bus.s_ack[r_sel];
  assign w_expired = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_rdata_nx = r_rdata;
    w_cnt_nx   = r_cnt;
    w_sreq_nx  = r_sreq;
    w_busy_nx  = r_busy;
    w_ack_nx   = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      IDLE: if (bus.m_req) begin
        w_state_nx = WAIT;
        w_sel_nx   = bus.m_addr[31:30];
        w_we_nx    = bus.m_we;
        w_addr_nx  = bus.m_addr[29:0];
        w_wdata_nx = bus.m_wdata;
        w_sreq_nx  = onehot4(bus.m_addr[31:30]);
        w_busy_nx  = 1'b1;
        w_cnt_nx   = '0;
      end
      // an ack on the final counter cycle still completes normally
      WAIT: if (w_hit) begin
        w_state_nx = DONE;
        w_rdata_nx = r_we ? '0 : w_sel_rdata;
        w_ack_nx   = 1'b1;
        w_sreq_nx  = '0;
      end else if (w_expired) begin
        w_state_nx = DONE;
        w_rdata_nx = ERR_DATA;
        w_err_nx   = 1'b1;
        w_sreq_nx  = '0;
      end else begin
        w_cnt_nx = r_cnt + 8'd1;
      end
      DONE: begin
        w_state_nx = IDLE;
        w_busy_nx  = 1'b0;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_sreq  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_rdata <= w_rdata_nx;
      r_cnt   <= w_cnt_nx;
      r_sreq  <= w_sreq_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_busy  <= w_busy_nx;
    end
  assign bus.m_rdata = r_rdata;
  assign bus.m_ack   = r_ack;
  assign bus.m_err   = r_err;
  assign bus.m_busy  = r_busy;
  assign bus.s_req   = r_sreq;
  assign bus.s_we    = r_we;
  assign bus.s_addr  = {2'b00, r_addr};
  assign bus.s_wdata = r_wdata;
endmodule

// File: tb/tb_bus_demux4_32.sv
// tb_bus_demux4_32: directed and randomized transactions checked against a per-transaction expectation model
module tb_bus_demux4_32;
  localparam int          TO  = 15;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] slv_rd [4];
  bus_demux4_32_if bus ();
  bus_demux4_32 #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.s_rdata0 = slv_rd[0];
  assign bus.s_rdata1 = slv_rd[1];
  assign bus.s_rdata2 = slv_rd[2];
  assign bus.s_rdata3 = slv_rd[3];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rand_slaves();
    for (int i = 0; i < 4; i++) slv_rd[i] = $urandom;
  endtask
  // ack_at: WAIT cycle (1-based) in which the selected slave acks; beyond TO means it never does
  task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input int ack_at, input logic [3:0] noise);
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    int          n;
    mask   = 4'b0001 << addr[31:30];
    n      = ack_at <= TO ? ack_at : TO;
    exp_rd = ack_at > TO ? ERR : we ? 32'h0 : slv_rd[addr[31:30]];
    bus.m_req = 1'b1; bus.m_we = we; bus.m_addr = addr; bus.m_wdata = wd;
    bus.s_ack = noise & ~mask;
    @(posedge clk); #1;
    bus.m_req = 1'b0; bus.m_we = ~we; bus.m_addr = $urandom; bus.m_wdata = $urandom;
    for (int c = 1; c <= n; c++) begin
      bus.s_ack = (noise & ~mask) | (c == ack_at ? mask : 4'b0000);
      @(negedge clk);
      chk("wait_s_req", bus.s_req, mask);
      chk("wait_s_addr", bus.s_addr, {2'b00, addr[29:0]});
      chk("wait_s_we", bus.s_we, we);
      chk("wait_s_wdata", bus.s_wdata, wd);
      chk("wait_busy", bus.m_busy, 1);
      chk("wait_ack_err", {bus.m_ack, bus.m_err}, 0);
      @(posedge clk); #1;
    end
    bus.s_ack = noise & ~mask;
    @(negedge clk);
    chk("done_ack", bus.m_ack, ack_at <= TO);
    chk("done_err", bus.m_err, ack_at > TO);
    chk("done_rdata", bus.m_rdata, exp_rd);
    chk("done_s_req", bus.s_req, 0);
    chk("done_busy", bus.m_busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", bus.m_busy, 0);
    chk("idle_ack_err", {bus.m_ack, bus.m_err}, 0);
    chk("idle_rdata_hold", bus.m_rdata, exp_rd);
    @(posedge clk); #1;
    bus.s_ack = 4'b0000;
  endtask
  logic [31:0] a;
  logic        w;
  initial begin
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.s_ack = '0;
    rand_slaves();
    #1;
    chk("rst_outputs", {bus.m_ack, bus.m_err, bus.m_busy, bus.s_we, bus.s_req}, 0);
    chk("rst_rdata", bus.m_rdata, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wdata", bus.s_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    slv_rd[1] = 32'h1234_5678;
    txn(32'h4000_0008, 1'b0, 32'h0, 3, 4'b0000);
    txn(32'hC000_0004, 1'b1, 32'hA5A5_0F0F, 1, 4'b0000);
    rand_slaves();
    txn(32'h8000_0020, 1'b0, 32'h0, 1000, 4'b0000);
    rand_slaves();
    txn(32'h0000_0100, 1'b0, 32'h0, TO, 4'b0110);
    for (int k = 0; k < 20; k++) begin
      rand_slaves();
      txn($urandom, 1'($urandom), $urandom, $urandom_range(1, TO + 3), 4'($urandom));
    end
    bus.m_req = 1'b1; bus.s_ack = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      a = $urandom; w = 1'($urandom);
      rand_slaves();
      bus.m_addr = a; bus.m_we = w; bus.m_wdata = $urandom;
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_s_req", bus.s_req, 4'b0001 << a[31:30]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_ack", bus.m_ack, 1);
      chk("b2b_s_req_done", bus.s_req, 0);
      chk("b2b_rdata", bus.m_rdata, w ? 32'h0 : slv_rd[a[31:30]]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_idle", {bus.s_req, bus.m_busy, bus.m_ack}, 0);
    end
    bus.m_req = 1'b0; bus.s_ack = 4'b0000;
    @(posedge clk); #1;
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h8000_0010;
    @(posedge clk); #1 bus.m_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_s_req", bus.s_req, 0);
    chk("rst_mid_busy", bus.m_busy, 0);
    chk("rst_mid_ack_err", {bus.m_ack, bus.m_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < TO + 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus.m_ack, bus.m_err, bus.m_busy, bus.s_req}, 0);
    end
    @(posedge clk); #1;
    rand_slaves();
    txn(32'h8000_0010, 1'b0, 32'h0, 2, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
